// File: rtl/mul_pkg.sv
// Shared definitions for the mul5 arbiter/sequencer: op encodings, FSM states
// and the multiplier compute length.
package mul_pkg;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  localparam int unsigned MUL_CYCLES = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mul5.sv
// Iterative radix-4 Booth multiplier: reset loads y, then five compute cycles
// retire four Booth digits (eight multiplier bits) each; frozen after that.
module mul5
  import mul_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        x_signed,
  input  logic        y_signed,
  output logic [31:0] ml,
  output logic [31:0] mh
);

  logic [63:0] acc;
  logic [40:0] ysh;
  logic [2:0]  cnt;
  logic [63:0] xe;
  logic [63:0] step;

  always_comb begin
    xe   = {{32{x_signed & x[31]}}, x};
    step = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      case (ysh[2*k +: 3])
        3'b001, 3'b010: step = step + (xe << (2*k));
        3'b011:         step = step + (xe << (2*k + 1));
        3'b100:         step = step - (xe << (2*k + 1));
        3'b101, 3'b110: step = step - (xe << (2*k));
        default:        ;
      endcase
    end
  end

  // y is sign/zero-extended to 40 bits with the implicit Booth bit at ysh[0];
  // the high extension bits then yield zero digits.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
      cnt <= '0;
      ysh <= {{8{y_signed & y[31]}}, y, 1'b0};
    end else if (cnt < 3'(MUL_CYCLES)) begin
      acc <= acc + (step << {cnt, 3'b000});
      ysh <= {{8{ysh[40]}}, ysh[40:8]};
      cnt <= cnt + 3'd1;
    end
  end

  assign ml = acc[31:0];
  assign mh = acc[63:32];

endmodule

// File: rtl/mul_arb.sv
// Two-port round-robin arbiter and sequencer in front of the shared mul5
// multiplier, returning results on one tagged response channel.
module mul_arb
  import mul_pkg::*;
#(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [31:0]      req0_x,
  input  logic [31:0]      req0_y,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [31:0]      req1_x,
  input  logic [31:0]      req1_y,
  input  logic [TAG_W-1:0] req1_tag,
  input  logic             flush,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_port,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      rsp_data,
  output logic             busy
);

  state_t           state, state_n;
  logic             prio;
  logic [2:0]       cnt;
  logic [31:0]      x_q, y_q;
  logic [1:0]       op_q;
  logic [TAG_W-1:0] tag_q;
  logic             port_q;
  logic             grant_port, grant_valid;
  logic             x_signed, y_signed, mul_start;
  logic [31:0]      ml, mh;

  always_comb begin
    state_n     = state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    grant_port  = (req0_valid && req1_valid) ? prio : req1_valid;
    grant_valid = (req0_valid || req1_valid) && !flush && !reset;
    case (state)
      ST_IDLE: if (grant_valid) begin
        req0_ready = !grant_port;
        req1_ready = grant_port;
        state_n    = ST_START;
      end
      ST_START: state_n = flush ? ST_IDLE : ST_BUSY;
      ST_BUSY: begin
        if (flush)                               state_n = ST_IDLE;
        else if (cnt == 3'(MUL_CYCLES - 1))      state_n = ST_DONE;
      end
      ST_DONE: if (flush || rsp_ready) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      prio   <= 1'b0;
      cnt    <= '0;
      x_q    <= '0;
      y_q    <= '0;
      op_q   <= OP_MUL;
      tag_q  <= '0;
      port_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && grant_valid) begin
        x_q    <= grant_port ? req1_x   : req0_x;
        y_q    <= grant_port ? req1_y   : req0_y;
        op_q   <= grant_port ? req1_op  : req0_op;
        tag_q  <= grant_port ? req1_tag : req0_tag;
        port_q <= grant_port;
        prio   <= !grant_port;
      end
      if (state == ST_START)     cnt <= '0;
      else if (state == ST_BUSY) cnt <= cnt + 3'd1;
    end
  end

  assign x_signed  = (op_q == OP_MULH) || (op_q == OP_MULHSU);
  assign y_signed  = (op_q == OP_MULH);
  assign mul_start = (state == ST_START) || reset;

  mul5 u_mul (
    .clk      (clk),
    .reset    (mul_start),
    .x        (x_q),
    .y        (y_q),
    .x_signed (x_signed),
    .y_signed (y_signed),
    .ml       (ml),
    .mh       (mh)
  );

  // Response fields are forced to zero outside DONE so reset values hold at once.
  assign rsp_valid = (state == ST_DONE);
  assign rsp_data  = rsp_valid ? ((op_q == OP_MUL) ? ml : mh) : '0;
  assign rsp_tag   = rsp_valid ? tag_q : '0;
  assign rsp_port  = rsp_valid && port_q;
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_mul_arb.sv
// Self-checking bench for mul_arb: directed vector table, multi-cycle corner
// sequences, and random requests against a 64-bit arithmetic product model.
module tb_mul_arb;
  import mul_pkg::*;

  localparam int unsigned TAG_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]       req0_op, req1_op;
  logic [31:0]      req0_x, req0_y, req1_x, req1_y;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic             flush, rsp_valid, rsp_ready, rsp_port, busy;
  logic [TAG_W-1:0] rsp_tag;
  logic [31:0]      rsp_data;

  mul_arb #(.TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_x(req0_x), .req0_y(req0_y), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_x(req1_x), .req1_y(req1_y), .req1_tag(req1_tag),
    .flush(flush), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_port(rsp_port), .rsp_tag(rsp_tag), .rsp_data(rsp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int total    = 0;
  bit rsp_hold = 0;

  typedef struct {
    bit          port;
    logic [1:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] a, b, p;
    a = (op == OP_MULH || op == OP_MULHSU) ? {{32{x[31]}}, x} : {32'b0, x};
    b = (op == OP_MULH) ? {{32{y[31]}}, y} : {32'b0, y};
    p = a * b;
    return (op == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  task automatic drive(input bit p, input bit v, input logic [1:0] op,
                       input logic [31:0] x, input logic [31:0] y, input logic [3:0] tag);
    if (p) begin
      req1_valid = v; req1_op = op; req1_x = x; req1_y = y; req1_tag = tag;
    end else begin
      req0_valid = v; req0_op = op; req0_x = x; req0_y = y; req0_tag = tag;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting cycle.
  task automatic send(input bit p, input logic [1:0] op, input logic [31:0] x,
                      input logic [31:0] y, input logic [3:0] tag, output int t_acc);
    bit got = 0;
    t_acc = -1;
    drive(p, 1'b1, op, x, y, tag);
    for (int i = 0; i < 60 && !got; i++) begin
      #1;
      if ((p ? req1_ready : req0_ready) === 1'b1) begin
        got = 1; t_acc = cyc;
      end
      @(negedge clk);
    end
    if (p) req1_valid = 1'b0; else req0_valid = 1'b0;
    check("accepted", {63'b0, got}, 64'd1);
  endtask

  task automatic wait_rsp(output int t_rsp);
    t_rsp = -1;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid === 1'b1) begin
        t_rsp = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic goto(input int n);
    for (int i = 0; i < 100 && cyc < n; i++) @(negedge clk);
  endtask

  task automatic run_one(input bit p, input logic [1:0] op, input logic [31:0] x,
                         input logic [31:0] y, input logic [3:0] tag, input logic [31:0] exp);
    int t, r;
    send(p, op, x, y, tag, t);
    wait_rsp(r);
    check("latency", 64'(r - t), 64'd7);
    check("rsp_data", {32'b0, rsp_data}, {32'b0, exp});
    check("rsp_tag", {60'b0, rsp_tag}, {60'b0, tag});
    check("rsp_port", {63'b0, rsp_port}, {63'b0, p});
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = rsp_hold;
  endtask

  task automatic idle_no_rsp(input string name, input int n);
    int seen = 0;
    for (int i = 0; i < n; i++) begin
      if (rsp_valid === 1'b1) seen++;
      @(negedge clk);
    end
    check(name, 64'(seen), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int t, r, bad, chg;
    int q[$];
    logic [31:0] d0;
    logic [3:0]  tg0;
    logic        pt0;
    logic [1:0]  op;
    logic [31:0] x, y;

    vecs[0] = '{1'b0, OP_MUL,    32'd3,        32'd5,        4'h2, 32'h0000000F};
    vecs[1] = '{1'b1, OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 4'h3, 32'h00000000};
    vecs[2] = '{1'b1, OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 4'h4, 32'hFFFFFFFE};
    vecs[3] = '{1'b1, OP_MULHSU, 32'hFFFFFFFF, 32'd2,        4'h5, 32'hFFFFFFFF};
    vecs[4] = '{1'b1, OP_MULH,   32'h80000000, 32'h80000000, 4'h6, 32'h40000000};
    vecs[5] = '{1'b0, OP_MUL,    32'd7,        32'd6,        4'hE, 32'h0000002A};

    reset = 1'b1; flush = 1'b0; rsp_ready = 1'b0;
    drive(1'b0, 1'b0, 2'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 2'b0, '0, '0, '0);
    repeat (3) @(negedge clk);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    check("rst_rsp_data", {32'b0, rsp_data}, 64'd0);
    check("rst_rsp_tag", {60'b0, rsp_tag}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // directed vectors, consumer always ready
    rsp_hold = 1; rsp_ready = 1'b1;
    foreach (vecs[i]) run_one(vecs[i].port, vecs[i].op, vecs[i].x, vecs[i].y, vecs[i].tag, vecs[i].exp);
    rsp_hold = 0; rsp_ready = 1'b0;

    // round robin with both ports valid from reset
    reset = 1'b1;
    drive(1'b0, 1'b1, OP_MUL, 32'd2, 32'd3, 4'h1);
    drive(1'b1, 1'b1, OP_MUL, 32'd4, 32'd5, 4'h2);
    rsp_ready = 1'b1;
    #1;
    check("rst_ready0", {63'b0, req0_ready}, 64'd0);
    check("rst_ready1", {63'b0, req1_ready}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (req0_ready && req1_ready) bad++;
      else if (req0_ready) q.push_back(0);
      else if (req1_ready) q.push_back(1);
      @(negedge clk);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("rr_both_ready", 64'(bad), 64'd0);
    for (int i = 0; i < 4; i++)
      check("rr_grant", 64'((i < q.size()) ? q[i] : 2), 64'(i % 2));
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    rsp_ready = 1'b0;
    @(negedge clk);

    // stalled response; a pending request must not be granted meanwhile
    send(1'b0, OP_MUL, 32'h1234, 32'h10, 4'h5, t);
    wait_rsp(r);
    check("stall_latency", 64'(r - t), 64'd7);
    check("stall_data", {32'b0, rsp_data}, 64'h12340);
    d0 = rsp_data; tg0 = rsp_tag; pt0 = rsp_port;
    drive(1'b0, 1'b1, OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h9);
    drive(1'b1, 1'b1, OP_MULHSU, 32'hFFFFFFFF, 32'd3, 4'h7);
    bad = 0; chg = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (req0_ready || req1_ready) bad++;
      if (!rsp_valid || rsp_data !== d0 || rsp_tag !== tg0 || rsp_port !== pt0) chg++;
      @(negedge clk);
    end
    check("stall_no_ready", 64'(bad), 64'd0);
    check("stall_stable", 64'(chg), 64'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    check("resume_ready1", {63'b0, req1_ready}, 64'd1);
    check("resume_ready0", {63'b0, req0_ready}, 64'd0);
    req0_valid = 1'b0;
    t = cyc;
    @(negedge clk);
    req1_valid = 1'b0;
    wait_rsp(r);
    check("resume_latency", 64'(r - t), 64'd7);
    check("resume_data", {32'b0, rsp_data}, 64'hFFFFFFFF);
    check("resume_tag", {60'b0, rsp_tag}, 64'h7);
    check("resume_port", {63'b0, rsp_port}, 64'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // flush in IDLE blocks acceptance; flush mid-operation drops the response
    flush = 1'b1;
    drive(1'b0, 1'b1, OP_MUL, 32'd1, 32'd1, 4'h1);
    #1;
    check("flush_idle_ready", {63'b0, req0_ready}, 64'd0);
    req0_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle_busy", {63'b0, busy}, 64'd0);
    send(1'b0, OP_MUL, 32'd9, 32'd9, 4'h3, t);
    goto(t + 4);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {63'b0, busy}, 64'd0);
    idle_no_rsp("flush_no_rsp", 12);
    run_one(1'b0, OP_MUL, 32'd7, 32'd6, 4'h4, 32'h0000002A);

    // reset mid-operation, pointer returns to port 0
    send(1'b0, OP_MUL, 32'd100, 32'd200, 4'h6, t);
    goto(t + 3);
    reset = 1'b1;
    drive(1'b0, 1'b1, OP_MUL, 32'd1, 32'd2, 4'h1);
    drive(1'b1, 1'b1, OP_MUL, 32'd3, 32'd4, 4'h2);
    #1;
    check("arst_busy", {63'b0, busy}, 64'd0);
    check("arst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
    check("arst_outputs", {rsp_data, 27'b0, rsp_tag, rsp_port}, 64'd0);
    check("arst_ready", {62'b0, req0_ready, req1_ready}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("arst_prio", {62'b0, req0_ready, req1_ready}, 64'd2);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    idle_no_rsp("arst_no_rsp", 12);
    run_one(1'b1, OP_MULHU, 32'hDEADBEEF, 32'h12345678, 4'hB, model(OP_MULHU, 32'hDEADBEEF, 32'h12345678));

    // random requests against the arithmetic model
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: x = 32'h80000000;
        1: x = 32'hFFFFFFFF;
        default: x = $urandom;
      endcase
      y = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
      run_one(1'($urandom_range(0, 1)), op, x, y, 4'($urandom), model(op, x, y));
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/mul_arb.md
# mul_arb

Two-port arbiter and sequencer for the iterative radix-4 Booth multiplier `mul5`. It accepts multiply requests from two independent requesters (e.g. two issue slots) and grants them round-robin. For each granted request it latches the operands, drives the multiplier's start (its `reset` port) for one cycle, counts the five compute cycles, then returns the selected 32-bit result half on a single tagged response channel. The block sits between the issue logic and the shared multiplier, and is the only driver of the multiplier's ports.

## Interface
- `TAG_W`, default 4: width of the request/response tag.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `req0_valid`  in  1  port 0 request.
- `req0_ready`  out  1  port 0 accept; transfer occurs when valid&ready.
- `req0_op`  in  2  operation: 00 MUL (low half), 01 MULH (s×s), 10 MULHSU (x signed, y unsigned), 11 MULHU (u×u, high half).
- `req0_x`, `req0_y`  in  32  operands.
- `req0_tag`  in  TAG_W  tag, returned unchanged in the response.
- `req1_*`  same set as port 0, for port 1.
- `flush`  in  1  abandon the in-flight operation.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accept.
- `rsp_port`  out  1  originating port.
- `rsp_tag`  out  TAG_W  originating tag.
- `rsp_data`  out  32  result.
- `busy`  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, START, BUSY, DONE.
- IDLE:
  - `reqN_ready` = 1 only for the granted port, and only in IDLE.
  - Grant: if exactly one port is valid, grant it. If both are valid, grant the port selected by the `prio` pointer.
  - On a transfer: latch x, y, op, tag and port; set `prio` to the port not granted; go to START.
- START (1 cycle): multiplier `reset`=1, driven with the latched x, y, x_signed and y_signed. Go to BUSY with `cnt`=0.
- BUSY: `cnt` increments each cycle. After `cnt`=4, go to DONE.
- DONE:
  - `rsp_valid`=1.
  - `rsp_data` = `ml` for op 00, otherwise `mh`.
  - Go to IDLE on `rsp_ready`. No new grant occurs in the same cycle.
- Signedness per op:
  - 00: x_signed=0, y_signed=0.
  - 01: x_signed=1, y_signed=1.
  - 10: x_signed=1, y_signed=0.
  - 11: x_signed=0, y_signed=0.
- Operands and signedness are held constant from START through DONE, because the multiplier samples x, x_signed and y_signed every compute cycle.
- `flush`:
  - In START, BUSY or DONE: go to IDLE next cycle with no response. `prio` keeps its updated value.
  - In IDLE: suppresses `req_ready`, so nothing is accepted that cycle.
- Multiplier `reset` = (state==START) | `reset`. While idle, the multiplier state is don't-care.

## Timing
- Accept in cycle T → START in T+1 → BUSY in T+2..T+6 → `rsp_valid` in T+7. Minimum interval between accepts is 8 cycles.
- `rsp_data`, `rsp_tag` and `rsp_port` are stable while `rsp_valid`=1 and `rsp_ready`=0. The multiplier does not update for its internal count > 4.
- Reset values: state=IDLE, `prio`=0, `cnt`=0, `req0_ready`=`req1_ready`=0, `rsp_valid`=0, `rsp_port`=0, `rsp_tag`=0, `rsp_data`=0, `busy`=0.
- Asserting `reset` in any state aborts immediately: no response, and the pointer returns to 0.
- `flush` and `rsp_ready` in the same DONE cycle: flush wins, and the response is counted as not delivered.
- A request deasserted before it is granted is simply not accepted. Requesters must hold valid and payload until ready.

## Structure
- Package `mul_pkg`:
  - op encoding constants `OP_MUL`, `OP_MULH`, `OP_MULHSU`, `OP_MULHU`;
  - state enum;
  - `MUL_CYCLES` = 5.
- One sub-module: `mul5` instantiated as `u_mul`. Arbitration and FSM logic stay inline.

## Test plan
- Port 0, MUL, x=3, y=5, tag=0x2 → `rsp_valid` at T+7, `rsp_data`=0x0000000F, `rsp_tag`=0x2, `rsp_port`=0.
- Port 1, four back-to-back requests with `rsp_ready`=1:
  - MULH, 0xFFFFFFFF×0xFFFFFFFF → 0x00000000.
  - MULHU, same operands → 0xFFFFFFFE.
  - MULHSU, x=0xFFFFFFFF, y=2 → 0xFFFFFFFF.
  - MULH, 0x80000000×0x80000000 → 0x40000000.
- Both ports valid continuously from reset → grant order 0,1,0,1. `req_ready` is never high for both ports in the same cycle.
- `rsp_ready`=0 for 10 cycles in DONE → data, tag and port constant. Neither `req_ready` asserts. Accept resumes the cycle after `rsp_ready`.
- `flush` at T+4 → IDLE at T+5, no `rsp_valid`. The next request, MUL 7×6, returns 0x0000002A.
- `reset` asserted at T+3 → all outputs at reset values in the same cycle, no response. A post-reset request completes correctly.
